// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM encoding, default
// bit period and the idle level of the serial line.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_e;

  localparam int   DEFAULT_CLKS_PER_BIT = 16;
  localparam logic LINE_IDLE            = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each serial bit, wrapping to zero on that cycle or whenever clr is high.
module uart_bit_timer
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_WIDTH    = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  output logic bit_end
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  assign bit_end = (cnt_q == CNT_WIDTH'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || bit_end) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a synchronous FIFO and sends them as start/data(LSB first)/stop
// frames. Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit before stop.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_WIDTH    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  output logic             fifo_rd_en_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic             frame_done_o
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [IDX_W-1:0] bit_idx_q;
  logic             tx_q;
  logic             rd_en_q;
  logic             busy_q;
  logic             timer_clr;
  logic             bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic             parity_q;
`endif

  // Timer is held at zero until the first START cycle so every bit is full length.
  assign timer_clr = (state_q == IDLE) || (state_q == FETCH) || (state_q == LOAD);
  assign shift_d   = shift_q >> 1;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (timer_clr),
    .bit_end (bit_end)
  );

  // Outputs are assigned with the value they must carry in the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= LINE_IDLE;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_i && !fifo_empty_i) begin
            state_q <= FETCH;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          state_q <= LOAD;
          rd_en_q <= 1'b0;
        end
        LOAD: begin
          state_q   <= START;
          shift_q   <= fifo_rdata_i;
          bit_idx_q <= '0;
          tx_q      <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_q  <= ^fifo_rdata_i;
`endif
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_q <= shift_d;
            if (bit_idx_q == LAST_IDX) begin
`ifdef FIFO_UART_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= parity_q;
`else
              state_q <= STOP;
              tx_q    <= LINE_IDLE;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              tx_q      <= shift_d[0];
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            tx_q    <= LINE_IDLE;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            tx_q    <= LINE_IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
          tx_q    <= LINE_IDLE;
        end
      endcase
    end
  end

  assign fifo_rd_en_o = rd_en_q;
  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign frame_done_o = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a FIFO model feeds bytes, a line monitor
// decodes tx_o frames and compares them against queued expectations.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int N = FRAME_BITS * CPB;

  typedef struct {
    logic [7:0] data;
    bit         chk_lat;
    bit         chk_gap;
    int         abort_k;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       enable_i;
  logic       fifo_empty_i;
  logic [7:0] fifo_rdata_i;
  logic       fifo_rd_en_o;
  logic       tx_o;
  logic       busy_o;
  logic       frame_done_o;

  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  int   pops = 0;
  int   last_rd_cyc = 0;
  int   empty_fall_cyc = 0;
  int   prev_end_cyc = 0;
  bit   mon_on = 1'b0;
  bit   in_frame = 1'b0;
  logic rd_prev = 1'b0;
  logic tx_prev = 1'b1;
  int   k = 0;
  int   bit_err, busy_err, fd_err;
  logic [7:0] rxd;
  exp_t cur;
  exp_t sb[$];
  logic [7:0] fifo_q[$];

  fifo_uart_tx #(
    .WIDTH        (8),
    .CLKS_PER_BIT (CPB),
    .CNT_WIDTH    (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int bi);
    if (bi == 0) return 1'b0;
    if (bi <= 8) return d[bi-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (bi == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // FIFO model: pops on rd_en, presents data for the following cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (fifo_rd_en_o === 1'b1) begin
        if (fifo_q.size() == 0) begin
          total++;
          $display("FAIL fifo_underflow: pop with empty FIFO (cycle %0d)", cyc);
        end else begin
          fifo_rdata_i = fifo_q.pop_front();
        end
      end
      if (fifo_empty_i && fifo_q.size() != 0) empty_fall_cyc = cyc;
      fifo_empty_i = (fifo_q.size() == 0);
    end
  end

  // Line monitor: decodes frames and compares against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (rd_prev === 1'b1) check("rd_pulse_width", int'(fifo_rd_en_o), 0);
        if (fifo_rd_en_o === 1'b1 && rd_prev !== 1'b1) begin
          pops++;
          last_rd_cyc = cyc;
        end
        rd_prev = fifo_rd_en_o;
        if (!in_frame) begin
          if (frame_done_o !== 1'b0) check("frame_done_outside_frame", int'(frame_done_o), 0);
          if (tx_prev === 1'b1 && tx_o === 1'b0) begin
            if (sb.size() == 0) begin
              check("unexpected_frame", 1, 0);
            end else begin
              cur = sb.pop_front();
              in_frame = 1'b1;
              k = 0;
              bit_err = 0;
              busy_err = 0;
              fd_err = 0;
              rxd = '0;
              check("rd_to_start", cyc - last_rd_cyc, 2);
              if (cur.chk_lat) check("empty_to_start", cyc - empty_fall_cyc, 3);
              if (cur.chk_gap) check("frame_gap", cyc - prev_end_cyc, 4);
            end
          end
        end
        if (in_frame) begin
          if (k == cur.abort_k) begin
            check("abort_tx", int'(tx_o), 1);
            check("abort_busy", int'(busy_o), 0);
            check("abort_no_done", fd_err + int'(frame_done_o), 0);
            in_frame = 1'b0;
          end else begin
            if (tx_o !== exp_bit(cur.data, k / CPB)) bit_err++;
            if (busy_o !== 1'b1) busy_err++;
            if (frame_done_o !== (k == N - 1)) fd_err++;
            if ((k % CPB) == CPB / 2 && (k / CPB) >= 1 && (k / CPB) <= 8)
              rxd[(k / CPB) - 1] = tx_o;
            if (k == N - 1) begin
              check("frame_data", int'(rxd), int'(cur.data));
              check("frame_bits", bit_err, 0);
              check("frame_busy", busy_err, 0);
              check("frame_done_pulse", fd_err, 0);
              prev_end_cyc = cyc;
              in_frame = 1'b0;
            end
            k++;
          end
        end
        tx_prev = tx_o;
      end
    end
  end

  task automatic send(input exp_t e);
    @(posedge clk);
    #1;
    sb.push_back(e);
    fifo_q.push_back(e.data);
  endtask

  task automatic wait_sb(input int left, input int bound);
    int n = 0;
    while ((sb.size() != left || in_frame) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", int'(n < bound), 1);
  endtask

  task automatic wait_tx_low(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_o !== 1'b0 && n < bound);
    check("frame_start_in_time", int'(n < bound), 1);
  endtask

  initial begin
    int tx_bad;
    int busy_bad;
    rst_i = 1'b1;
    enable_i = 1'b0;
    fifo_empty_i = 1'b1;
    fifo_rdata_i = '0;

    @(posedge clk);
    @(negedge clk);
    check("reset_tx", int'(tx_o), 1);
    check("reset_busy", int'(busy_o), 0);
    check("reset_rd_en", int'(fifo_rd_en_o), 0);
    check("reset_done", int'(frame_done_o), 0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    enable_i = 1'b1;
    mon_on = 1'b1;

    tx_bad = 0;
    busy_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_o !== 1'b1) tx_bad++;
      if (busy_o !== 1'b0) busy_bad++;
    end
    check("empty_idle_tx", tx_bad, 0);
    check("empty_idle_busy", busy_bad, 0);
    check("empty_idle_pops", pops, 0);

    send('{data: 8'hA5, chk_lat: 1'b1, chk_gap: 1'b0, abort_k: -1});
    wait_sb(0, 200);
    check("pops_after_a5", pops, 1);

    send('{data: 8'h00, chk_lat: 1'b1, chk_gap: 1'b0, abort_k: -1});
    send('{data: 8'hFF, chk_lat: 1'b0, chk_gap: 1'b1, abort_k: -1});
    wait_sb(0, 300);
    check("pops_after_b2b", pops, 3);

    send('{data: 8'h3C, chk_lat: 1'b1, chk_gap: 1'b0, abort_k: -1});
    send('{data: 8'h81, chk_lat: 1'b0, chk_gap: 1'b0, abort_k: -1});
    send('{data: 8'h42, chk_lat: 1'b0, chk_gap: 1'b1, abort_k: -1});
    wait_tx_low(50);
    repeat (10) @(negedge clk);
    enable_i = 1'b0;
    wait_sb(2, 200);
    repeat (30) @(negedge clk);
    check("no_fetch_while_disabled", pops, 4);
    check("bytes_left_in_fifo", fifo_q.size(), 2);
    check("tx_idle_while_disabled", int'(tx_o), 1);
    enable_i = 1'b1;
    wait_sb(0, 400);
    check("pops_after_resume", pops, 6);

    send('{data: 8'hE7, chk_lat: 1'b1, chk_gap: 1'b0, abort_k: 20});
    wait_tx_low(50);
    repeat (19) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    repeat (20) @(negedge clk);
    check("post_abort_tx", int'(tx_o), 1);
    check("post_abort_busy", int'(busy_o), 0);
    check("post_abort_pops", pops, 7);
    check("post_abort_sb_empty", sb.size(), 0);

    send('{data: 8'h07, chk_lat: 1'b1, chk_gap: 1'b0, abort_k: -1});
    wait_sb(0, 200);
    repeat (10) @(negedge clk);
    check("final_pops", pops, 8);
    check("final_fifo_empty", fifo_q.size(), 0);
    check("final_in_frame", int'(in_frame), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
